// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and the single-step wrap helper for the PWM channel array
package pwm_pkg;
   localparam int PWM_W = 13;
   typedef logic [PWM_W-1:0] pwm_t;
   typedef logic signed [PWM_W+1:0] pwm_ext_t;
   typedef enum logic [1:0] {OFF, ON, NORM} pwm_mode_t;
   typedef struct packed {
      pwm_t      cyc;
      pwm_t      rise;
      pwm_t      fall;
      pwm_mode_t mode;
   } pwm_set_t;
   // folds a value back into [0,c) with a single add or subtract of c
   function automatic pwm_t wrap_once(input pwm_ext_t v, input pwm_t c);
      pwm_ext_t w;
      w = pwm_ext_t'({2'b00, c});
      return (v < 0) ? pwm_t'(v + w) : (v >= w) ? pwm_t'(v - w) : pwm_t'(v);
   endfunction
endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one transducer channel with staged/pending/active parameter sets, time counter and comparator
module pwm_channel
   import pwm_pkg::*;
#(
   parameter pwm_t CYCLE_DEFAULT = pwm_t'(5000)
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic sync_i,
   input  logic update_i,
   input  pwm_t cycle_i,
   input  pwm_t duty_i,
   input  pwm_t phase_i,
   output logic pend_o,
   output logic pwm_o
);
   pwm_t cyc_c, cyc_s_q, duty_s_q, phase_s_q, t_q, t_d;
   logic stg_v_q, pend_q, pend_d, pwm_q, pwm_d, wrap, apply;
   pwm_set_t stage_set, pen_q, pen_d, act_q, act_d;
   pwm_ext_t rise_raw, fall_raw;

   assign cyc_c = (cycle_i < pwm_t'(2)) ? pwm_t'(2) : cycle_i;
   assign rise_raw = pwm_ext_t'({2'b00, phase_s_q}) - pwm_ext_t'({3'b000, duty_s_q[PWM_W-1:1]});
   assign fall_raw = pwm_ext_t'({2'b00, phase_s_q}) + pwm_ext_t'({2'b00, duty_s_q})
                   - pwm_ext_t'({3'b000, duty_s_q[PWM_W-1:1]});

   always_comb begin
      stage_set = '{cyc: cyc_s_q, rise: wrap_once(rise_raw, cyc_s_q), fall: wrap_once(fall_raw, cyc_s_q),
                    mode: (duty_s_q == '0) ? OFF : (duty_s_q == cyc_s_q) ? ON : NORM};
      wrap = t_q == act_q.cyc - pwm_t'(1);
      apply = pend_q && (wrap || sync_i);
      t_d = (wrap || sync_i) ? '0 : t_q + pwm_t'(1);
      act_d = apply ? pen_q : act_q;
      // a freshly computed set always wins over clearing, so it waits for the next wrap
      pen_d = stg_v_q ? stage_set : pen_q;
      pend_d = stg_v_q || (pend_q && !apply);
      pwm_d = (act_q.mode == ON) || ((act_q.mode == NORM) &&
              ((act_q.rise < act_q.fall) ? (t_q >= act_q.rise && t_q < act_q.fall)
                                         : (t_q >= act_q.rise || t_q < act_q.fall)));
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         stg_v_q   <= 1'b0;
         cyc_s_q   <= '0;
         duty_s_q  <= '0;
         phase_s_q <= '0;
         pen_q     <= '0;
         pend_q    <= 1'b0;
         act_q     <= '{cyc: CYCLE_DEFAULT, rise: '0, fall: '0, mode: OFF};
         t_q       <= '0;
         pwm_q     <= 1'b0;
      end else begin
         stg_v_q <= update_i;
         if (update_i) begin
            cyc_s_q   <= cyc_c;
            duty_s_q  <= (duty_i > cyc_c) ? cyc_c : duty_i;
            phase_s_q <= phase_i;
         end
         pen_q  <= pen_d;
         pend_q <= pend_d;
         act_q  <= act_d;
         t_q    <= t_d;
         pwm_q  <= pwm_d;
      end
   end

   assign pend_o = pend_q;
   assign pwm_o  = pwm_q;
endmodule

// File: rtl/pwm_array.sv
// pwm_array: array of independent PWM channels sharing SYNC/UPDATE strobes, with an aggregate pending flag
module pwm_array
   import pwm_pkg::*;
#(
   parameter int WIDTH         = PWM_W,
   parameter int TRANS_NUM     = 249,
   parameter int CYCLE_DEFAULT = 5000
) (
   input  logic                             CLK,
   input  logic                             RST_N,
   input  logic                             SYNC,
   input  logic                             UPDATE,
   input  logic [TRANS_NUM-1:0][WIDTH-1:0]  CYCLE,
   input  logic [TRANS_NUM-1:0][WIDTH-1:0]  DUTY,
   input  logic [TRANS_NUM-1:0][WIDTH-1:0]  PHASE,
   output logic                             PENDING,
   output logic [TRANS_NUM-1:0]             PWM_OUT
);
   logic [TRANS_NUM-1:0] pend;

   for (genvar i = 0; i < TRANS_NUM; i++) begin : g_ch
      pwm_channel #(.CYCLE_DEFAULT(pwm_t'(CYCLE_DEFAULT))) u_ch (
         .clk_i   (CLK),
         .rst_ni  (RST_N),
         .sync_i  (SYNC),
         .update_i(UPDATE),
         .cycle_i (CYCLE[i]),
         .duty_i  (DUTY[i]),
         .phase_i (PHASE[i]),
         .pend_o  (pend[i]),
         .pwm_o   (PWM_OUT[i])
      );
   end

   assign PENDING = |pend;
endmodule
